// File: rtl/echo_pkg.sv
// Shared types and constants for the echo loopback queue.
// Entries are packed {meth, v}; DELAY_W sizes the head hold timer.
package echo_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int DELAY_W    = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] meth;
      logic [DATA_WIDTH-1:0] v;
   } echo_entry_t;

endpackage

// File: rtl/echo_fifo.sv
// In-order entry storage for echo_queue: circular array, wrapping pointers and
// an occupancy counter from which full/empty are derived.
module echo_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic          push_acc,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   // A full queue still takes a write when the head leaves in the same cycle;
   // wr_ptr == rd_ptr then, and the head is read before the slot is rewritten.
   assign push_acc  = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_acc && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !push_acc)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/echo_queue.sv
// Echo responder queue: captures say/say2 requests (say2 field-swapped) and
// replays each head entry as a heard indication after a programmable hold.
module echo_queue #(
   parameter int DATA_WIDTH = echo_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4,
   parameter int DELAY      = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   say__ENA,
   input  logic [DATA_WIDTH-1:0]  say_meth,
   input  logic [DATA_WIDTH-1:0]  say_v,
   output logic                   say__RDY,
   input  logic                   say2__ENA,
   input  logic [DATA_WIDTH-1:0]  say2_meth,
   input  logic [DATA_WIDTH-1:0]  say2_v,
   output logic                   say2__RDY,
   output logic                   heard__ENA,
   output logic [DATA_WIDTH-1:0]  heard_meth,
   output logic [DATA_WIDTH-1:0]  heard_v,
   input  logic                   heard__RDY,
   output logic [$clog2(DEPTH):0] count,
   output logic [15:0]            heard_total,
   output logic                   err_collide
);

   import echo_pkg::*;

   localparam int                 EW        = 2 * DATA_WIDTH;
   localparam int                 CW        = $clog2(DEPTH) + 1;
   localparam logic [DELAY_W-1:0] HOLD_INIT = DELAY_W'(DELAY);

   logic [EW-1:0]      push_data;
   logic [EW-1:0]      head_data;
   logic               push;
   logic               push_acc;
   logic               pop;
   logic               full;
   logic               empty;
   logic               head_load;
   logic [DELAY_W-1:0] hold;

   // On a collision the say entry wins; say2 is dropped and flagged.
   assign push      = say__ENA | say2__ENA;
   assign push_data = say__ENA ? {say_meth, say_v} : {say2_v, say2_meth};

   assign say__RDY   = !full;
   assign say2__RDY  = !full;
   assign pop        = !empty && (hold == '0) && heard__RDY;
   assign heard__ENA = pop;
   assign heard_meth = empty ? '0 : head_data[EW-1:DATA_WIDTH];
   assign heard_v    = empty ? '0 : head_data[DATA_WIDTH-1:0];

   // A fresh head appears on enqueue into empty, or when a pop exposes the next entry.
   assign head_load  = (push_acc && empty) || (pop && ((count > CW'(1)) || push_acc));

   echo_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .push_acc  (push_acc),
      .head_data (head_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold        <= '0;
         heard_total <= '0;
         err_collide <= 1'b0;
      end else begin
         if (say__ENA && say2__ENA)
            err_collide <= 1'b1;
         if (pop)
            heard_total <= heard_total + 16'd1;
         if (head_load)
            hold <= HOLD_INIT;
         else if (hold != '0)
            hold <= hold - DELAY_W'(1);
      end
   end

endmodule

// File: tb/tb_echo_queue.sv
// Directed bench for echo_queue: one DELAY=1 instance for ordering/flow/reset
// scenarios and one DELAY=0 instance for minimum latency and counter wrap.
module tb_echo_queue;

   import echo_pkg::*;

   localparam int DW = 32;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic          say_ena, say2_ena, heard_rdy;
   logic [DW-1:0] say_meth, say_v, say2_meth, say2_v;
   logic          say_rdy, say2_rdy, heard_ena;
   logic [DW-1:0] heard_meth, heard_v;
   logic [2:0]    count;
   logic [15:0]   heard_total;
   logic          err_collide;

   logic          z_say_ena, z_say2_ena, z_heard_rdy;
   logic [DW-1:0] z_say_meth, z_say_v, z_say2_meth, z_say2_v;
   logic          z_say_rdy, z_say2_rdy, z_heard_ena;
   logic [DW-1:0] z_heard_meth, z_heard_v;
   logic [2:0]    z_count;
   logic [15:0]   z_heard_total;
   logic          z_err_collide;

   int total_n = 0;
   int bad_n   = 0;

   echo_queue #(.DATA_WIDTH(DW), .DEPTH(4), .DELAY(1)) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .say__ENA    (say_ena),
      .say_meth    (say_meth),
      .say_v       (say_v),
      .say__RDY    (say_rdy),
      .say2__ENA   (say2_ena),
      .say2_meth   (say2_meth),
      .say2_v      (say2_v),
      .say2__RDY   (say2_rdy),
      .heard__ENA  (heard_ena),
      .heard_meth  (heard_meth),
      .heard_v     (heard_v),
      .heard__RDY  (heard_rdy),
      .count       (count),
      .heard_total (heard_total),
      .err_collide (err_collide)
   );

   echo_queue #(.DATA_WIDTH(DW), .DEPTH(4), .DELAY(0)) u_dut0 (
      .CLK         (CLK),
      .RST         (RST),
      .say__ENA    (z_say_ena),
      .say_meth    (z_say_meth),
      .say_v       (z_say_v),
      .say__RDY    (z_say_rdy),
      .say2__ENA   (z_say2_ena),
      .say2_meth   (z_say2_meth),
      .say2_v      (z_say2_v),
      .say2__RDY   (z_say2_rdy),
      .heard__ENA  (z_heard_ena),
      .heard_meth  (z_heard_meth),
      .heard_v     (z_heard_v),
      .heard__RDY  (z_heard_rdy),
      .count       (z_count),
      .heard_total (z_heard_total),
      .err_collide (z_err_collide)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for the next indication, then checks its payload.
   task automatic expect_heard(input string tag, input echo_entry_t e);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!heard_ena && n < 20);
      check_val({tag, "_ena"}, 64'(heard_ena), 64'(1));
      check_val({tag, "_meth"}, 64'(heard_meth), 64'(e.meth));
      check_val({tag, "_v"}, 64'(heard_v), 64'(e.v));
   endtask

   task automatic push_say(input logic [DW-1:0] m, input logic [DW-1:0] v);
      say_meth = m;
      say_v    = v;
      say_ena  = 1'b1;
      @(negedge CLK);
      say_ena  = 1'b0;
   endtask

   initial begin
      logic seen;
      int   n;
      say_ena = 0; say2_ena = 0; heard_rdy = 1;
      say_meth = '0; say_v = '0; say2_meth = '0; say2_v = '0;
      z_say_ena = 0; z_say2_ena = 0; z_heard_rdy = 1;
      z_say_meth = '0; z_say_v = '0; z_say2_meth = '0; z_say2_v = '0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      check_val("rst_count", 64'(count), 64'(0));
      check_val("rst_say_rdy", 64'(say_rdy), 64'(1));
      check_val("rst_say2_rdy", 64'(say2_rdy), 64'(1));
      check_val("rst_heard_ena", 64'(heard_ena), 64'(0));
      check_val("rst_heard_meth", 64'(heard_meth), 64'(0));
      check_val("rst_total", 64'(heard_total), 64'(0));
      check_val("rst_err", 64'(err_collide), 64'(0));
      RST = 1'b0;
      @(negedge CLK);

      // single say, DELAY=1: fires two cycles after the request cycle
      say_meth = 5; say_v = 9; say_ena = 1;
      @(negedge CLK);
      say_ena = 0;
      check_val("say_t1_ena", 64'(heard_ena), 64'(0));
      check_val("say_t1_count", 64'(count), 64'(1));
      @(negedge CLK);
      check_val("say_t2_ena", 64'(heard_ena), 64'(1));
      check_val("say_t2_meth", 64'(heard_meth), 64'(5));
      check_val("say_t2_v", 64'(heard_v), 64'(9));
      @(negedge CLK);
      check_val("say_total", 64'(heard_total), 64'(1));
      check_val("say_empty", 64'(count), 64'(0));

      // say2 swaps fields
      say2_meth = 32'hA; say2_v = 32'hB; say2_ena = 1;
      @(negedge CLK);
      say2_ena = 0;
      check_val("say2_t1_ena", 64'(heard_ena), 64'(0));
      @(negedge CLK);
      check_val("say2_t2_ena", 64'(heard_ena), 64'(1));
      check_val("say2_meth", 64'(heard_meth), 64'(32'hB));
      check_val("say2_v", 64'(heard_v), 64'(32'hA));
      @(negedge CLK);
      check_val("say2_total", 64'(heard_total), 64'(2));

      // fill with downstream stalled; fifth request is ignored
      heard_rdy = 0;
      for (int k = 0; k < 5; k++) begin
         say_meth = DW'(k + 1); say_v = DW'(16 + k); say_ena = 1;
         @(negedge CLK);
         if (k == 3) begin
            check_val("fill_say_rdy", 64'(say_rdy), 64'(0));
            check_val("fill_say2_rdy", 64'(say2_rdy), 64'(0));
            check_val("fill_count", 64'(count), 64'(4));
         end
      end
      say_ena = 0;
      check_val("fifth_ignored", 64'(count), 64'(4));
      check_val("stall_ena", 64'(heard_ena), 64'(0));
      heard_rdy = 1;
      #1;
      check_val("resume_ena", 64'(heard_ena), 64'(1));
      check_val("resume_meth", 64'(heard_meth), 64'(1));
      check_val("resume_v", 64'(heard_v), 64'(16));
      for (int j = 1; j < 8; j++) begin
         @(negedge CLK);
         check_val($sformatf("drain_ena_%0d", j), 64'(heard_ena), 64'(j % 2 == 0));
         if (j % 2 == 0) begin
            check_val($sformatf("drain_meth_%0d", j), 64'(heard_meth), 64'(j / 2 + 1));
            check_val($sformatf("drain_v_%0d", j), 64'(heard_v), 64'(16 + j / 2));
         end
         if (j == 1) begin
            check_val("rdy_back", 64'(say_rdy), 64'(1));
            check_val("rdy_back_count", 64'(count), 64'(3));
         end
      end
      check_val("drain_count", 64'(count), 64'(0));
      check_val("drain_total", 64'(heard_total), 64'(6));

      // collision: say kept, say2 dropped, flag sticky
      heard_rdy = 0;
      say_meth = 0; say_v = 1; say_ena = 1;
      say2_meth = 0; say2_v = 2; say2_ena = 1;
      @(negedge CLK);
      say_ena = 0; say2_ena = 0;
      check_val("coll_count", 64'(count), 64'(1));
      check_val("coll_err", 64'(err_collide), 64'(1));
      check_val("coll_v", 64'(heard_v), 64'(1));
      heard_rdy = 1;
      expect_heard("coll_out", {32'h0, 32'h1});
      @(negedge CLK);
      check_val("coll_drained", 64'(count), 64'(0));
      check_val("coll_err_sticky", 64'(err_collide), 64'(1));

      // full queue: push and pop together keep occupancy at DEPTH
      heard_rdy = 0;
      for (int k = 0; k < 4; k++)
         push_say(DW'(32'h21 + k), DW'(32'h31 + k));
      @(negedge CLK);
      check_val("fp_full", 64'(count), 64'(4));
      heard_rdy = 1;
      say_meth = 32'h25; say_v = 32'h35; say_ena = 1;
      #1;
      check_val("fp_pop_ena", 64'(heard_ena), 64'(1));
      check_val("fp_pop_meth", 64'(heard_meth), 64'(32'h21));
      @(negedge CLK);
      say_ena = 0;
      check_val("fp_count", 64'(count), 64'(4));
      expect_heard("fp_22", {32'h22, 32'h32});
      expect_heard("fp_23", {32'h23, 32'h33});
      expect_heard("fp_24", {32'h24, 32'h34});
      expect_heard("fp_25", {32'h25, 32'h35});
      @(negedge CLK);
      check_val("fp_empty", 64'(count), 64'(0));
      check_val("fp_total", 64'(heard_total), 64'(12));

      // asynchronous reset flushes pending entries mid-cycle
      heard_rdy = 0;
      push_say(32'h41, 32'h51);
      push_say(32'h42, 32'h52);
      repeat (2) @(negedge CLK);
      @(posedge CLK);
      #3;
      heard_rdy = 1;
      #1;
      check_val("ar_pre_ena", 64'(heard_ena), 64'(1));
      RST = 1'b1;
      #1;
      check_val("ar_ena", 64'(heard_ena), 64'(0));
      check_val("ar_count", 64'(count), 64'(0));
      check_val("ar_total", 64'(heard_total), 64'(0));
      check_val("ar_err", 64'(err_collide), 64'(0));
      check_val("ar_say_rdy", 64'(say_rdy), 64'(1));
      @(negedge CLK);
      RST = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         seen = seen | heard_ena;
      end
      check_val("ar_no_ind", 64'(seen), 64'(0));
      check_val("ar_total_after", 64'(heard_total), 64'(0));

      // DELAY=0: indication the cycle after the request
      z_say_meth = 32'h77; z_say_v = 32'h88; z_say_ena = 1;
      @(negedge CLK);
      z_say_ena = 0;
      check_val("d0_ena", 64'(z_heard_ena), 64'(1));
      check_val("d0_meth", 64'(z_heard_meth), 64'(32'h77));
      check_val("d0_v", 64'(z_heard_v), 64'(32'h88));
      @(negedge CLK);
      check_val("d0_total", 64'(z_heard_total), 64'(1));
      check_val("d0_count", 64'(z_count), 64'(0));

      // stream 65535 more echoes back to back; total wraps to zero
      z_say_meth = 32'h5; z_say_v = 32'h6; z_say_ena = 1;
      for (int i = 0; i < 65535; i++) begin
         @(negedge CLK);
         if (i == 100) begin
            check_val("wrap_stream_count", 64'(z_count), 64'(1));
            check_val("wrap_stream_ena", 64'(z_heard_ena), 64'(1));
         end
      end
      z_say_ena = 0;
      check_val("wrap_pre", 64'(z_heard_total), 64'(16'hFFFF));
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (z_count != 0 && n < 10);
      check_val("wrap_count", 64'(z_count), 64'(0));
      check_val("wrap_total", 64'(z_heard_total), 64'(0));

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
